// File: rtl/lvg_sequencer.sv
// Instruction sequencer and timing controller for the lvg matmul datapath.
// Decodes load/store/matmul opcodes and drives the sys/dis/agg count schedule.
module lvg_sequencer #(
   parameter int N         = 4,
   parameter int CW        = 8,
   parameter int DIS_START = N + 1,
   parameter int ACT_LAT   = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    instr,
   input  logic          instr_valid,
   output logic          instr_ready,
   output logic          load_l,
   output logic          load_r,
   output logic          load_a,
   output logic          store_en,
   output logic [CW-1:0] sys_count,
   output logic [CW-1:0] dis_count,
   output logic [CW-1:0] agg_count,
   output logic          agg_act_sel,
   output logic          should_add,
   output logic          should_act,
   output logic          sys_rst,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [7:0] OP_LOAD_L     = 8'd1;
   localparam logic [7:0] OP_LOAD_R     = 8'd2;
   localparam logic [7:0] OP_LOAD_A     = 8'd3;
   localparam logic [7:0] OP_STORE      = 8'd4;
   localparam logic [7:0] OP_MUL        = 8'd5;
   localparam logic [7:0] OP_MUL_ADD    = 8'd6;
   localparam logic [7:0] OP_MUL_ACT    = 8'd7;
   localparam logic [7:0] OP_MUL_ADD_AC = 8'd8;

   logic [0:0]    state_r;
   logic          load_l_r, load_r_r, load_a_r, store_en_r;
   logic [CW-1:0] sys_count_r, dis_count_r, agg_count_r;
   logic          should_add_r, should_act_r;
   logic          sys_rst_r, busy_r, done_r, err_r;

   logic [CW-1:0] next_k_s;
   logic [CW-1:0] kend_s;
   int            lat_s;

   // Dispatcher row index for feed index k (0 outside the dispatch window).
   function automatic logic [CW-1:0] dis_at(input int k);
      if (k >= DIS_START && k <= DIS_START + N - 1) begin
         dis_at = CW'(k - DIS_START + 1);
      end else begin
         dis_at = {CW{1'b0}};
      end
   endfunction

   // Aggregator row index: the dispatcher index from lat cycles earlier.
   function automatic logic [CW-1:0] agg_at(input int k, input int lat);
      if (k - lat >= 1) begin
         agg_at = dis_at(k - lat);
      end else begin
         agg_at = {CW{1'b0}};
      end
   endfunction

   // Schedule helpers derived from the current run's activation mode.
   always_comb begin
      next_k_s = sys_count_r + {{(CW-1){1'b0}}, 1'b1};
      if (should_act_r) begin
         lat_s = 1 + ACT_LAT;
      end else begin
         lat_s = 1;
      end
      kend_s = CW'(DIS_START + N + lat_s);
   end

   // Main sequencer: decode in IDLE, step the count schedule in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         load_l_r     <= 1'b0;
         load_r_r     <= 1'b0;
         load_a_r     <= 1'b0;
         store_en_r   <= 1'b0;
         sys_count_r  <= {CW{1'b0}};
         dis_count_r  <= {CW{1'b0}};
         agg_count_r  <= {CW{1'b0}};
         should_add_r <= 1'b0;
         should_act_r <= 1'b0;
         sys_rst_r    <= 1'b1;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         load_l_r   <= 1'b0;
         load_r_r   <= 1'b0;
         load_a_r   <= 1'b0;
         store_en_r <= 1'b0;
         sys_rst_r  <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (instr_valid) begin
                  case (instr)
                     OP_LOAD_L: load_l_r   <= 1'b1;
                     OP_LOAD_R: load_r_r   <= 1'b1;
                     OP_LOAD_A: load_a_r   <= 1'b1;
                     OP_STORE:  store_en_r <= 1'b1;
                     OP_MUL, OP_MUL_ADD, OP_MUL_ACT, OP_MUL_ADD_AC: begin
                        should_add_r <= (instr == OP_MUL_ADD) || (instr == OP_MUL_ADD_AC);
                        should_act_r <= (instr == OP_MUL_ACT) || (instr == OP_MUL_ADD_AC);
                        state_r      <= ST_RUN;
                        busy_r       <= 1'b1;
                        sys_count_r  <= {{(CW-1){1'b0}}, 1'b1};
                        dis_count_r  <= dis_at(1);
                        agg_count_r  <= {CW{1'b0}};
                     end
                     default: err_r <= 1'b1;
                  endcase
               end
            end
            ST_RUN: begin
               if (sys_count_r == kend_s) begin
                  state_r     <= ST_IDLE;
                  busy_r      <= 1'b0;
                  sys_count_r <= {CW{1'b0}};
                  dis_count_r <= {CW{1'b0}};
                  agg_count_r <= {CW{1'b0}};
               end else begin
                  sys_count_r <= next_k_s;
                  dis_count_r <= dis_at(int'(next_k_s));
                  agg_count_r <= agg_at(int'(next_k_s), lat_s);
                  // Completion cycle also clears the array for the next run.
                  if (next_k_s == kend_s) begin
                     done_r    <= 1'b1;
                     sys_rst_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign instr_ready = (state_r == ST_IDLE) && !rst;
   assign load_l      = load_l_r;
   assign load_r      = load_r_r;
   assign load_a      = load_a_r;
   assign store_en    = store_en_r;
   assign sys_count   = sys_count_r;
   assign dis_count   = dis_count_r;
   assign agg_count   = agg_count_r;
   assign agg_act_sel = should_act_r;
   assign should_add  = should_add_r;
   assign should_act  = should_act_r;
   assign sys_rst     = sys_rst_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign err         = err_r;

endmodule
